// File: rtl/instruction_fetch_unit_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package instruction_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] WORD_INC         = 32'd4;
    localparam logic [31:0] WORD_OFFSET_MASK = 32'h0000_0003;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        KILL  = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory, hazard/redirect and IF/ID signals of the fetch stage.
interface instruction_fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_pc4;
    logic        IF_ID_valid;

    modport master (
        output imem_req, imem_addr, IF_ID_instruction, IF_ID_pc4, IF_ID_valid,
        input  imem_rdata, imem_valid, stall, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, IF_ID_instruction, IF_ID_pc4, IF_ID_valid,
        output imem_rdata, imem_valid, stall, branch_taken, branch_target
    );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: flush to NOP takes priority over load.
module instruction_fetch_unit_if_id_register
    import instruction_fetch_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    logic [31:0] r_instr;
    logic [31:0] r_pc4;
    logic        r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr <= NOP_INSTR;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (i_flush) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_pc4   <= i_pc4;
            r_valid <= 1'b1;
        end
    end

    assign o_instr = r_instr;
    assign o_pc4   = r_pc4;
    assign o_valid = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, req/valid fetch FSM, one-entry skid buffer, branch kill.
// Optional IFU_PERF_CNT_EN adds fetch_count / stall_cycles outputs.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
`ifdef IFU_PERF_CNT_EN
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles,
`endif
    instruction_fetch_unit_if.master ifu_bus
);

    ifu_state_e  r_state;
    ifu_state_e  w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_kill_addr;
    logic [31:0] r_skid;
    logic        r_active;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic        w_req;
    logic        w_xfer;
    logic        w_avail;
    logic        w_load;
    logic        w_flush;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pc4;

    assign w_pc_plus4 = r_pc + WORD_INC;
    assign w_target   = ifu_bus.branch_target & ~WORD_OFFSET_MASK;
    // r_active keeps the request low for the first cycle out of reset.
    assign w_req      = r_active && (r_state != HOLD);
    assign w_xfer     = w_req && ifu_bus.imem_valid;

    // When ID advances with nothing new to hand it, IF/ID becomes a bubble.
    assign w_avail      = (r_state == HOLD) || ((r_state == FETCH) && w_xfer);
    assign w_load       = !ifu_bus.branch_taken && !ifu_bus.stall && w_avail;
    assign w_flush      = ifu_bus.branch_taken || (!ifu_bus.stall && !w_avail);
    assign w_load_instr = (r_state == HOLD) ? r_skid : ifu_bus.imem_rdata;
    assign w_load_pc4   = (r_state == HOLD) ? r_pc : w_pc_plus4;

    assign ifu_bus.imem_req  = w_req;
    assign ifu_bus.imem_addr = (r_state == KILL) ? r_kill_addr : r_pc;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (ifu_bus.branch_taken) begin
                    w_state_next = (w_req && !ifu_bus.imem_valid) ? KILL : FETCH;
                end else if (w_xfer && ifu_bus.stall) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (ifu_bus.branch_taken || !ifu_bus.stall) begin
                    w_state_next = FETCH;
                end
            end
            KILL: begin
                if (w_xfer) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= FETCH;
            r_active    <= 1'b0;
            r_pc        <= RESET_PC;
            r_kill_addr <= RESET_PC;
            r_skid      <= NOP_INSTR;
        end else begin
            r_state  <= w_state_next;
            r_active <= 1'b1;
            if (ifu_bus.branch_taken) begin
                r_pc <= w_target;
                // A second redirect while killing must keep the owed address.
                if (r_state == FETCH) begin
                    r_kill_addr <= r_pc;
                end
            end else if ((r_state == FETCH) && w_xfer) begin
                r_pc <= w_pc_plus4;
            end
            if ((r_state == FETCH) && w_xfer && ifu_bus.stall && !ifu_bus.branch_taken) begin
                r_skid <= ifu_bus.imem_rdata;
            end
        end
    end

    instruction_fetch_unit_if_id_register u_if_id (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_instr (w_load_instr),
        .i_pc4   (w_load_pc4),
        .o_instr (ifu_bus.IF_ID_instruction),
        .o_pc4   (ifu_bus.IF_ID_pc4),
        .o_valid (ifu_bus.IF_ID_valid)
    );

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count  <= '0;
            stall_cycles <= '0;
        end else begin
            if ((r_state == FETCH) && w_xfer && !ifu_bus.branch_taken) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (ifu_bus.stall && ifu_bus.IF_ID_valid) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
